// File: rtl/ritc_max_window_ctrl.sv
// Sequencer around the RITC compare tree: flushes the tree pipeline, tracks the
// window maximum of max_i, compares it to a threshold and reports via valid/ready.
module ritc_max_window_ctrl #(
    parameter int NUM_BITS     = 12,
    parameter int TREE_LATENCY = 4,
    parameter int WINDOW_BITS  = 8,
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [WINDOW_BITS-1:0]  window_len_i,
    input  logic [NUM_BITS-1:0]     threshold_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic [NUM_BITS-1:0]     max_i,
    output logic                    busy_o,
    output logic                    start_drop_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [NUM_BITS-1:0]     result_max_o,
    output logic                    result_trig_o
);

    typedef enum logic [2:0] {IDLE, FLUSH, ACCUM, REPORT, HOLDOFF} state_t;

    localparam int FLUSH_W = (TREE_LATENCY > 1) ? $clog2(TREE_LATENCY) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST =
        (TREE_LATENCY > 0) ? FLUSH_W'(TREE_LATENCY - 1) : '0;

    state_t                  state;
    state_t                  next_state;
    logic [FLUSH_W-1:0]      flush_cnt;
    logic [WINDOW_BITS:0]    sample_cnt;
    logic [WINDOW_BITS:0]    sample_next;
    logic [WINDOW_BITS:0]    win_total;
    logic [WINDOW_BITS-1:0]  len_q;
    logic [NUM_BITS-1:0]     thr_q;
    logic [HOLDOFF_BITS-1:0] hold_q;
    logic [HOLDOFF_BITS-1:0] hold_cnt;
    logic [NUM_BITS-1:0]     run_max;
    logic [NUM_BITS-1:0]     accum_max;
    logic                    flush_done;
    logic                    window_done;
    logic                    hold_done;

    // A zero window length means the full 2**WINDOW_BITS samples.
    assign win_total   = (len_q == '0) ? {1'b1, {WINDOW_BITS{1'b0}}} : {1'b0, len_q};
    assign sample_next = sample_cnt + 1'b1;
    assign window_done = (sample_next == win_total);
    assign flush_done  = (flush_cnt == FLUSH_LAST);
    assign hold_done   = (hold_cnt == hold_q - 1'b1);
    assign accum_max   = ((sample_cnt == '0) || (max_i > run_max)) ? max_i : run_max;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = (TREE_LATENCY == 0) ? ACCUM : FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (window_done) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                if (result_ready_i) begin
                    next_state = (result_trig_o && (hold_q != '0)) ? HOLDOFF : IDLE;
                end
            end
            HOLDOFF: begin
                if (hold_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state != IDLE);
        result_valid_o = (state == REPORT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_drop_o  <= 1'b0;
            flush_cnt     <= '0;
            sample_cnt    <= '0;
            len_q         <= '0;
            thr_q         <= '0;
            hold_q        <= '0;
            hold_cnt      <= '0;
            run_max       <= '0;
            result_max_o  <= '0;
            result_trig_o <= 1'b0;
        end else begin
            start_drop_o <= start_i && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q      <= window_len_i;
                        thr_q      <= threshold_i;
                        hold_q     <= holdoff_i;
                        flush_cnt  <= '0;
                        sample_cnt <= '0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
                ACCUM: begin
                    run_max    <= accum_max;
                    sample_cnt <= sample_next;
                    if (window_done) begin
                        result_max_o  <= accum_max;
                        result_trig_o <= (accum_max > thr_q);
                    end
                end
                REPORT: begin
                    if (result_ready_i) begin
                        hold_cnt <= '0;
                    end
                end
                HOLDOFF: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ritc_max_window_ctrl.sv
// Self-checking bench for ritc_max_window_ctrl: table-driven windows plus
// hand-written backpressure, holdoff, full-window and reset sequences.
module tb_ritc_max_window_ctrl;

    localparam int NB = 12;
    localparam int L  = 4;
    localparam int WB = 8;
    localparam int HB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WB-1:0] window_len;
    logic [NB-1:0] threshold;
    logic [HB-1:0] holdoff;
    logic [NB-1:0] max_val;
    logic          busy;
    logic          start_drop;
    logic          result_valid;
    logic          result_ready;
    logic [NB-1:0] result_max;
    logic          result_trig;

    typedef struct {
        logic [NB-1:0] max;
        logic          trig;
    } res_t;

    typedef struct {
        logic [WB-1:0]        len;
        logic [NB-1:0]        thr;
        logic [HB-1:0]        hold;
        logic [0:7][NB-1:0]   samp;
        logic [NB-1:0]        exp_max;
        logic                 exp_trig;
    } vec_t;

    res_t          sb[$];
    logic [NB-1:0] stim[$];
    vec_t          vecs[8];
    int            checks = 0;
    int            errors = 0;

    ritc_max_window_ctrl #(
        .NUM_BITS(NB), .TREE_LATENCY(L), .WINDOW_BITS(WB), .HOLDOFF_BITS(HB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .window_len_i(window_len),
        .threshold_i(threshold),
        .holdoff_i(holdoff),
        .max_i(max_val),
        .busy_o(busy),
        .start_drop_o(start_drop),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .result_max_o(result_max),
        .result_trig_o(result_trig)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_drop"},  32'(start_drop), 32'd0);
        check({tag, "_max"},   32'(result_max), 32'd0);
        check({tag, "_trig"},  32'(result_trig), 32'd0);
    endtask

    task automatic setVec(input int i, input logic [WB-1:0] len, input logic [NB-1:0] thr,
                          input logic [HB-1:0] hold, input logic [0:7][NB-1:0] samp,
                          input logic [NB-1:0] em, input logic et);
        vecs[i].len      = len;
        vecs[i].thr      = thr;
        vecs[i].hold     = hold;
        vecs[i].samp     = samp;
        vecs[i].exp_max  = em;
        vecs[i].exp_trig = et;
    endtask

    // Starts a window at the current negedge, feeds flush_val during the tree
    // latency, then the samples in stim, then after_val; pushes the expectation.
    task automatic applyStimulus(input string tag, input logic [WB-1:0] len,
                                 input logic [NB-1:0] thr, input logic [HB-1:0] hold,
                                 input logic [NB-1:0] flush_val, input logic [NB-1:0] after_val,
                                 input logic [NB-1:0] em, input logic et);
        int w;
        w          = stim.size();
        start      = 1'b1;
        window_len = len;
        threshold  = thr;
        holdoff    = hold;
        max_val    = flush_val;
        @(negedge clk);
        start      = 1'b0;
        window_len = ~len;
        threshold  = ~thr;
        holdoff    = ~hold;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        for (int i = 0; i < L; i++) @(negedge clk);
        for (int j = 0; j < w; j++) begin
            max_val = stim[j];
            if (j == w - 1) check({tag, "_valid_early"}, 32'(result_valid), 32'd0);
            @(negedge clk);
        end
        max_val = after_val;
        sb.push_back('{max: em, trig: et});
    endtask

    // Compares the reported result, optionally stalls ready (with an optional
    // dropped start inside the stall), completes the handshake and checks busy.
    task automatic checkOutput(input string tag, input int stall, input int drop_at,
                               input logic [HB-1:0] hold);
        res_t e;
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected one result", tag);
            e = '{max: '0, trig: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_max"},  32'(result_max), 32'(e.max));
        check({tag, "_trig"}, 32'(result_trig), 32'(e.trig));
        result_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            if (i == drop_at + 1) check({tag, "_drop"}, 32'(start_drop), 32'd1);
            start = (i == drop_at);
            if (i == drop_at) begin
                window_len = 8'd1;
                threshold  = 12'hFFF;
            end
            @(negedge clk);
            check({tag, "_stable"}, 32'({result_valid, result_trig, result_max}),
                  32'({1'b1, e.trig, e.max}));
        end
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'(e.trig && (hold != '0)));
        check({tag, "_valid_after"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        window_len   = '0;
        threshold    = '0;
        holdoff      = '0;
        max_val      = '0;
        result_ready = 1'b0;

        setVec(0, 8'd4, 12'd100,  8'd0, {12'd10, 12'd200, 12'd50, 12'd199, 48'd0}, 12'd200, 1'b1);
        setVec(1, 8'd4, 12'd100,  8'd0, {12'd5, 12'd5, 12'd5, 12'd5, 48'd0}, 12'd5, 1'b0);
        setVec(2, 8'd3, 12'd77,   8'd9, {12'd77, 12'd10, 12'd77, 60'd0}, 12'd77, 1'b0);
        setVec(3, 8'd1, 12'd0,    8'd0, {12'd1, 84'd0}, 12'd1, 1'b1);
        setVec(4, 8'd5, 12'd4094, 8'd0, {12'd4095, 12'd0, 12'd4095, 12'd3, 12'd2, 36'd0}, 12'd4095, 1'b1);
        setVec(5, 8'd6, 12'd300,  8'd0, {12'd300, 12'd299, 12'd0, 12'd0, 12'd0, 12'd0, 24'd0}, 12'd300, 1'b0);
        setVec(6, 8'd2, 12'd10,   8'd0, {12'd0, 12'd0, 72'd0}, 12'd0, 1'b0);
        setVec(7, 8'd8, 12'd799,  8'd0, {12'd800, 12'd700, 12'd600, 12'd500,
                                         12'd400, 12'd300, 12'd200, 12'd100}, 12'd800, 1'b1);

        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table windows, back-to-back with ready already high.
        for (int v = 0; v < 8; v++) begin
            stim.delete();
            for (int j = 0; j < int'(vecs[v].len); j++) stim.push_back(vecs[v].samp[j]);
            applyStimulus($sformatf("vec%0d", v), vecs[v].len, vecs[v].thr, vecs[v].hold,
                          12'hFFF, 12'hFFF, vecs[v].exp_max, vecs[v].exp_trig);
            checkOutput($sformatf("vec%0d", v), 0, -1, vecs[v].hold);
        end

        // Backpressure for 10 cycles with a dropped start inside.
        stim = '{12'd1, 12'd2, 12'd3, 12'd150};
        applyStimulus("bp", 8'd4, 12'd100, 8'd0, 12'hFFF, 12'hFFF, 12'd150, 1'b1);
        checkOutput("bp", 10, 3, 8'd0);

        // Holdoff of 3 cycles after a triggered result.
        stim = '{12'd50, 12'd60};
        applyStimulus("ho", 8'd2, 12'd10, 8'd3, 12'd0, 12'd0, 12'd60, 1'b1);
        checkOutput("ho", 0, -1, 8'd3);
        start      = 1'b1;
        window_len = 8'd1;
        threshold  = 12'd0;
        @(negedge clk);
        start = 1'b0;
        check("ho_drop", 32'(start_drop), 32'd1);
        check("ho_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("ho_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        check("ho_idle", 32'(busy), 32'd0);
        check("ho_drop_end", 32'(start_drop), 32'd0);
        stim = '{12'd9};
        applyStimulus("ho_next", 8'd1, 12'd8, 8'd0, 12'hFFF, 12'hFFF, 12'd9, 1'b1);
        checkOutput("ho_next", 0, -1, 8'd0);

        // Full 256-sample window: last sample captured, the one after is not.
        stim.delete();
        for (int j = 0; j < 256; j++) stim.push_back((j == 255) ? 12'd1000 : 12'd7);
        applyStimulus("w256a", 8'd0, 12'd999, 8'd0, 12'hFFF, 12'd2000, 12'd1000, 1'b1);
        checkOutput("w256a", 0, -1, 8'd0);
        stim.delete();
        for (int j = 0; j < 256; j++) stim.push_back(12'd7);
        applyStimulus("w256b", 8'd0, 12'd7, 8'd0, 12'hFFF, 12'd3000, 12'd7, 1'b0);
        checkOutput("w256b", 0, -1, 8'd0);

        // Reset in the middle of accumulation.
        start      = 1'b1;
        window_len = 8'd8;
        threshold  = 12'd0;
        holdoff    = 8'd0;
        max_val    = 12'd900;
        @(negedge clk);
        start = 1'b0;
        repeat (L + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkReset("rst_accum");
        rst = 1'b0;

        // Reset while a result waits for ready; it must be discarded.
        stim = '{12'd321, 12'd5};
        applyStimulus("rr", 8'd2, 12'd300, 8'd0, 12'hFFF, 12'hFFF, 12'd321, 1'b1);
        check("rr_valid", 32'(result_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkReset("rst_report");
        rst = 1'b0;
        @(negedge clk);
        stim = '{12'd11, 12'd22, 12'd33};
        applyStimulus("fresh", 8'd3, 12'd22, 8'd0, 12'hFFF, 12'hFFF, 12'd33, 1'b1);
        checkOutput("fresh", 0, -1, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
